// File: rtl/swervolf_stats_pkg.sv
// swervolf_stats_pkg: shared FSM state type and default sizing for the branch statistics block
package swervolf_stats_pkg;
  typedef enum logic [1:0] {RUN, HOLD, CLEAR} state_t;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_REFRESH_CYC = 25_000_000;
endpackage

// File: rtl/swervolf_sat_counter.sv
// swervolf_sat_counter: W-bit up counter that sticks at all-ones instead of wrapping
//   clk, rstn : clock, asynchronous active-low reset
//   i_clr     : synchronous zero (wins over i_inc)
//   i_inc     : count one event
//   o_cnt     : current count
//   o_max     : count is all-ones
module swervolf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_max
);
  assign o_max = &o_cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) o_cnt <= '0;
    else if (i_clr) o_cnt <= '0;
    else if (i_inc && !o_max) o_cnt <= o_cnt + 1'b1;
endmodule

// File: rtl/swervolf_branch_stats.sv
// swervolf_branch_stats: saturating branch/taken counters with display-stable snapshots on a refresh tick
//   clk, rstn            : core clock, asynchronous active-low reset
//   i_br_valid/taken     : branch retire strobe and its taken qualifier
//   i_br_mispred         : mispredict qualifier (counted only with BRANCH_STATS_MISPRED_EN)
//   i_clr                : pulse, zero counters, snapshots and prescaler
//   i_freeze             : level, drop events while snapshots keep refreshing
//   o_branches/taken/mispred : snapshots, change only on o_snap_stb or clear
//   o_snap_stb           : one-cycle pulse when snapshots load
//   o_sat                : some live counter is at all-ones
//   Optional macro BRANCH_STATS_MISPRED_EN adds the mispredict counter.
module swervolf_branch_stats
  import swervolf_stats_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int REFRESH_CYC = DEF_REFRESH_CYC
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_br_valid,
  input  logic             i_br_taken,
  input  logic             i_br_mispred,
  input  logic             i_clr,
  input  logic             i_freeze,
  output logic [CNT_W-1:0] o_branches,
  output logic [CNT_W-1:0] o_taken,
  output logic [CNT_W-1:0] o_mispred,
  output logic             o_snap_stb,
  output logic             o_sat
);
  localparam int PW = $clog2(REFRESH_CYC);
  localparam logic [PW-1:0] TERM = PW'(REFRESH_CYC - 1);
  state_t state;
  logic [PW-1:0] pre;
  logic [CNT_W-1:0] br_cnt, tk_cnt, mp_cnt;
  logic br_max, tk_max, mp_max;
  logic clr_any, cnt_en, term;
  // Both the i_clr cycle and the following CLEAR cycle zero everything and drop events.
  assign clr_any = i_clr || state == CLEAR;
  assign cnt_en = state == RUN && !i_clr && i_br_valid;
  assign term = pre == TERM;
  swervolf_sat_counter #(.W(CNT_W)) u_br (
    .clk(clk), .rstn(rstn), .i_clr(clr_any), .i_inc(cnt_en), .o_cnt(br_cnt), .o_max(br_max)
  );
  // Taken only advances alongside branches, so it can never pass it.
  swervolf_sat_counter #(.W(CNT_W)) u_tk (
    .clk(clk), .rstn(rstn), .i_clr(clr_any), .i_inc(cnt_en && i_br_taken), .o_cnt(tk_cnt), .o_max(tk_max)
  );
`ifdef BRANCH_STATS_MISPRED_EN
  swervolf_sat_counter #(.W(CNT_W)) u_mp (
    .clk(clk), .rstn(rstn), .i_clr(clr_any), .i_inc(cnt_en && i_br_mispred), .o_cnt(mp_cnt), .o_max(mp_max)
  );
`else
  logic unused_mispred;
  assign unused_mispred = i_br_mispred;
  assign mp_cnt = '0;
  assign mp_max = 1'b0;
`endif
  // Counters only return to zero through clear, so their max flags are already sticky.
  assign o_sat = br_max || tk_max || mp_max;
  // Snapshots load from the pre-edge counts, so an event on the terminal cycle lands in the next tick.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= RUN;
      pre <= '0;
      o_snap_stb <= 1'b0;
      o_branches <= '0;
      o_taken <= '0;
      o_mispred <= '0;
    end else begin
      state <= i_clr ? CLEAR : i_freeze ? HOLD : RUN;
      o_snap_stb <= term && !clr_any;
      if (clr_any) begin
        pre <= '0;
        o_branches <= '0;
        o_taken <= '0;
        o_mispred <= '0;
      end else begin
        pre <= term ? '0 : pre + 1'b1;
        if (term) begin
          o_branches <= br_cnt;
          o_taken <= tk_cnt;
          o_mispred <= mp_cnt;
        end
      end
    end
endmodule

// File: tb/tb_swervolf_branch_stats.sv
// tb_swervolf_branch_stats: randomized scoreboard bench against a count-level reference model
module tb_swervolf_branch_stats;
  localparam int W = 8;
  localparam int R = 8;
  localparam int MAX = (1 << W) - 1;
  logic clk = 0, rstn = 0, v = 0, tk = 0, mp = 0, clr = 0, frz = 0;
  logic [W-1:0] ob, ot, om;
  logic stb, sat;
  typedef struct {int b; int t; int m;} snap_t;
  snap_t q[$];
  int compared = 0, mismatched = 0;
  int b = 0, t = 0, m = 0, cyc = 0, mode = 0, sb = 0, st = 0, sm = 0;
  bit exp_sat = 0;
  swervolf_branch_stats #(.CNT_W(W), .REFRESH_CYC(R)) dut (
    .clk(clk), .rstn(rstn), .i_br_valid(v), .i_br_taken(tk), .i_br_mispred(mp),
    .i_clr(clr), .i_freeze(frz), .o_branches(ob), .o_taken(ot), .o_mispred(om),
    .o_snap_stb(stb), .o_sat(sat)
  );
  always #5 clk = ~clk;
  function automatic int up(int x);
    return x < MAX ? x + 1 : x;
  endfunction
  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    snap_t s;
    #1;
    if (rstn) begin
      if (stb && q.size() == 0) chk("spurious_stb", 1, 0);
      else if (!stb && q.size() != 0) chk("missing_stb", 0, 1);
      else if (stb) begin
        s = q.pop_front();
        chk("stb_branches", ob, s.b);
        chk("stb_taken", ot, s.t);
        chk("stb_mispred", om, s.m);
      end
      chk("sat", sat, exp_sat);
      chk("hold_branches", ob, sb);
      chk("hold_taken", ot, st);
      chk("hold_mispred", om, sm);
    end
  end
  // Called at a negedge: applies inputs for the coming cycle and advances the model by the spec rules.
  task automatic step(bit iv, bit itk, bit imp, bit iclr, bit ifrz);
    v = iv; tk = itk; mp = imp; clr = iclr; frz = ifrz;
    if (iclr || mode == 2) begin
      b = 0; t = 0; m = 0; cyc = 0; sb = 0; st = 0; sm = 0;
    end else begin
      if (cyc == R - 1) begin
        q.push_back('{b, t, m});
        sb = b; st = t; sm = m; cyc = 0;
      end else cyc++;
      if (mode == 0 && iv) begin
        b = up(b);
        if (itk) t = up(t);
`ifdef BRANCH_STATS_MISPRED_EN
        if (imp) m = up(m);
`endif
      end
    end
    mode = iclr ? 2 : ifrz ? 1 : 0;
    exp_sat = b == MAX || t == MAX || m == MAX;
    @(negedge clk);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    #2 rstn = 0;
    #1;
    chk("rst_branches", ob, 0);
    chk("rst_taken", ot, 0);
    chk("rst_mispred", om, 0);
    chk("rst_stb", stb, 0);
    chk("rst_sat", sat, 0);
    v = 0; tk = 0; mp = 0; clr = 0; frz = 0;
    b = 0; t = 0; m = 0; cyc = 0; mode = 0; sb = 0; st = 0; sm = 0; exp_sat = 0;
    q.delete();
    @(negedge clk);
    rstn = 1;
  endtask
  initial begin
    bit fl;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, i < 3, 0, 0, 0);
    idle(2 * R);
    chk("t1_branches", ob, 5);
    chk("t1_taken", ot, 3);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
    idle(2 * R);
    chk("t2_branches", ob, 5);
    for (int i = 0; i < 300; i++) step(1, 1, 0, 0, 0);
    idle(R);
    chk("t3_branches", ob, MAX);
    chk("t3_taken", ot, MAX);
    chk("t3_sat", sat, 1);
    step(0, 0, 0, 1, 0);
    idle(1);
    chk("t3_clr_branches", ob, 0);
    chk("t3_clr_sat", sat, 0);
    step(1, 1, 0, 1, 0);
    idle(2 * R);
    chk("t4_branches", ob, 0);
    while (cyc != R - 1) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t5_this_tick", ob, 0);
    idle(R);
    chk("t5_next_tick", ob, 1);
    for (int i = 0; i < 6; i++) step(1, 0, i < 2, 0, 0);
    idle(2 * R);
`ifdef BRANCH_STATS_MISPRED_EN
    chk("t6_mispred", om, 2);
`else
    chk("t6_mispred", om, 0);
`endif
    fl = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) fl = !fl;
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 63) == 0, fl);
      if (i == 700) do_reset();
    end
    idle(2 * R);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
